// File: rtl/rr_interval_monitor.sv
// rr_interval_monitor
// Consumes the R-peak detector's 2-bit result stream. It measures R-R intervals in
// samples between accepted peaks, with a refractory window and an asystole timeout.
// Accepted intervals are queued in a small first-word-fall-through FIFO that has a
// valid/ready output.
module rr_interval_monitor #(
   parameter int CNT_W      = 12,
   parameter int REFRACT    = 50,
   parameter int TIMEOUT    = 2000,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clock_iht,
   input  logic             reset_n,
   input  logic             sample_en,
   input  logic [1:0]       peak_code,
   output logic [CNT_W-1:0] rr_data,
   output logic             rr_valid,
   input  logic             rr_ready,
   output logic             first_seen,
   output logic             asystole,
   output logic [7:0]       drop_cnt
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam logic [CNT_W:0]   REFRACT_D  = (CNT_W + 1)'(REFRACT);
   localparam logic [CNT_W:0]   TIMEOUT_D  = (CNT_W + 1)'(TIMEOUT);
   localparam logic [PTR_W:0]   OCC_FULL   = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [PTR_W:0]   OCC_ONE    = (PTR_W + 1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

   typedef enum logic [1:0] {
      WAIT_FIRST = 2'd0,
      MEASURE    = 2'd1,
      ASYSTOLE   = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Reset conditioning: assertion takes effect at once; release is aligned to the clock
   // ------------------------------------------------------------------
   logic [1:0] rst_sync_reg;
   logic       rst_int_n;

   // Two-flop release synchronizer. The asynchronous clear passes straight through.
   always_ff @(posedge clock_iht or negedge reset_n) begin
      if (!reset_n) begin
         rst_sync_reg <= 2'b00;
      end else begin
         rst_sync_reg <= {rst_sync_reg[0], 1'b1};
      end
   end

   assign rst_int_n = rst_sync_reg[1];

   // ------------------------------------------------------------------
   // Interval measurement FSM
   // ------------------------------------------------------------------
   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             first_seen_reg;
   logic             asystole_reg;
   logic             push_reg;
   logic [CNT_W-1:0] push_data_reg;

   logic             is_peak;
   logic [CNT_W:0]   d_ext;
   logic [CNT_W-1:0] d_sat;

   // Compute the distance to the current sample. d_ext keeps the carry, so the
   // threshold compares stay exact. d_sat is the saturated value that is stored.
   always_comb begin
      is_peak = (peak_code == 2'b01);
      d_ext   = {1'b0, cnt_reg} + {{CNT_W{1'b0}}, 1'b1};
      d_sat   = d_ext[CNT_W] ? CNT_MAX : d_ext[CNT_W-1:0];
   end

   // State, counter and sticky flags advance only on sample strobes.
   // An accepted interval is staged in push_reg and enters the FIFO on the next clock.
   always_ff @(posedge clock_iht or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_reg      <= WAIT_FIRST;
         cnt_reg        <= '0;
         first_seen_reg <= 1'b0;
         asystole_reg   <= 1'b0;
         push_reg       <= 1'b0;
         push_data_reg  <= '0;
      end else begin
         push_reg <= 1'b0;
         if (sample_en) begin
            case (state_reg)
               WAIT_FIRST: begin
                  cnt_reg <= '0;
                  if (is_peak) begin
                     first_seen_reg <= 1'b1;
                     state_reg      <= MEASURE;
                  end
               end
               MEASURE: begin
                  if (is_peak && (d_ext >= REFRACT_D)) begin
                     push_reg      <= 1'b1;
                     push_data_reg <= d_sat;
                     cnt_reg       <= '0;
                  end else if (d_ext >= TIMEOUT_D) begin
                     // A peak inside the refractory window does not count as an accept.
                     state_reg    <= ASYSTOLE;
                     asystole_reg <= 1'b1;
                     cnt_reg      <= d_sat;
                  end else begin
                     cnt_reg <= d_sat;
                  end
               end
               ASYSTOLE: begin
                  if (is_peak) begin
                     // The gap across the asystole is not a valid R-R interval,
                     // so restart the measurement without pushing.
                     cnt_reg      <= '0;
                     asystole_reg <= 1'b0;
                     state_reg    <= MEASURE;
                  end else begin
                     cnt_reg <= d_sat;
                  end
               end
               default: begin
                  state_reg <= WAIT_FIRST;
                  cnt_reg   <= '0;
               end
            endcase
         end
      end
   end

   // ------------------------------------------------------------------
   // Interval FIFO (first word fall through, registered head)
   // ------------------------------------------------------------------
   logic [CNT_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W:0]   occ_reg;
   logic [PTR_W:0]   occ_next;
   logic [CNT_W-1:0] rr_data_reg;
   logic [CNT_W-1:0] rr_data_next;
   logic [7:0]       drop_cnt_reg;

   logic             fifo_empty;
   logic             fifo_full;
   logic             pop;
   logic             wr_en;
   logic             drop;
   logic [PTR_W-1:0] rd_ptr_plus;

   // Handshake decode. With pop on the same edge, a push into a full FIFO is still accepted.
   always_comb begin
      fifo_empty  = (occ_reg == '0);
      fifo_full   = (occ_reg == OCC_FULL);
      pop         = !fifo_empty && rr_ready;
      wr_en       = push_reg && (!fifo_full || pop);
      drop        = push_reg && fifo_full && !pop;
      rd_ptr_plus = rd_ptr_reg + PTR_ONE;
   end

   // Occupancy update. A simultaneous push and pop leaves the occupancy unchanged.
   always_comb begin
      occ_next = occ_reg;
      if (wr_en && !pop) begin
         occ_next = occ_reg + OCC_ONE;
      end else if (!wr_en && pop) begin
         occ_next = occ_reg - OCC_ONE;
      end
   end

   // Next head word. It holds when the FIFO empties, so rr_data keeps the last value.
   always_comb begin
      rr_data_next = rr_data_reg;
      if (fifo_empty) begin
         if (push_reg) begin
            rr_data_next = push_data_reg;
         end
      end else if (pop) begin
         if (occ_reg > OCC_ONE) begin
            rr_data_next = mem[rd_ptr_plus];
         end else if (push_reg) begin
            rr_data_next = push_data_reg;
         end
      end
   end

   // Storage array without reset. A word is only read after it has been written.
   always_ff @(posedge clock_iht) begin
      if (wr_en) begin
         mem[wr_ptr_reg] <= push_data_reg;
      end
   end

   // Pointers, occupancy, head register and the saturating drop counter.
   always_ff @(posedge clock_iht or negedge rst_int_n) begin
      if (!rst_int_n) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         occ_reg      <= '0;
         rr_data_reg  <= '0;
         drop_cnt_reg <= 8'd0;
      end else begin
         if (wr_en) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_plus;
         end
         occ_reg     <= occ_next;
         rr_data_reg <= rr_data_next;
         if (drop && (drop_cnt_reg != 8'hFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 8'd1;
         end
      end
   end

   assign rr_data    = rr_data_reg;
   assign rr_valid   = !fifo_empty;
   assign first_seen = first_seen_reg;
   assign asystole   = asystole_reg;
   assign drop_cnt   = drop_cnt_reg;

endmodule
